// File: rtl/shift_pass_sequencer_if.sv
// Request, shifter-drive and result signals for shift_pass_sequencer.
// slave = sequencer side, master = requester/shifter/consumer side.
interface shift_pass_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  in_amt;
  logic        in_dir;
  logic [15:0] sh_a;
  logic [3:0]  sh_amt;
  logic        sh_choice;
  logic [15:0] sh_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] op_count;

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, sh_y, out_ready,
    output in_ready, sh_a, sh_amt, sh_choice, out_valid, out_data, op_count
  );

  modport master (
    output in_valid, in_data, in_amt, in_dir, sh_y, out_ready,
    input  in_ready, sh_a, sh_amt, sh_choice, out_valid, out_data, op_count
  );
endinterface

// File: rtl/shift_pass_sequencer.sv
// Splits a 0-31 bit logical shift into passes of <= MAX_STEP on an external 16-bit shifter;
// result after 1 (amt=0) or 1+ceil(amt/MAX_STEP) cycles, held until out_ready. SHIFT_PASS_OP_COUNT_EN adds op_count.
module shift_pass_sequencer #(
  parameter int MAX_STEP = 15
) (
  input logic                  clk,
  input logic                  reset,
  shift_pass_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [4:0] STEP_MAX = 5'(MAX_STEP);

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [4:0]  rem_q, rem_d;
  logic        dir_q, dir_d;
  logic [15:0] out_data_q, out_data_d;
  logic [4:0]  step;
  logic [4:0]  rem_left;
  logic        out_hs;

  always_comb begin
    step     = (rem_q > STEP_MAX) ? STEP_MAX : rem_q;
    rem_left = rem_q - step;
    out_hs   = (state_q == DONE) && bus.out_ready;
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    dir_d      = dir_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d = bus.in_data;
          rem_d = bus.in_amt;
          dir_d = bus.in_dir;
          if (bus.in_amt == 5'd0) begin
            out_data_d = bus.in_data;
            state_d    = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Each pass feeds the shifter result back as the next operand.
        acc_d = bus.sh_y;
        rem_d = rem_left;
        if (rem_left == 5'd0) begin
          out_data_d = bus.sh_y;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= 16'h0000;
      rem_q      <= 5'd0;
      dir_q      <= 1'b0;
      out_data_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      dir_q      <= dir_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_data_q;
  assign bus.sh_a      = acc_q;
  assign bus.sh_choice = dir_q;
  assign bus.sh_amt    = (state_q == RUN) ? step[3:0] : 4'd0;

`ifdef SHIFT_PASS_OP_COUNT_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb op_count_d = op_count_q + {15'd0, out_hs};

  always_ff @(posedge clk) begin
    if (reset) op_count_q <= 16'h0000;
    else       op_count_q <= op_count_d;
  end

  assign bus.op_count = op_count_q;
`else
  logic unused_hs;
  assign unused_hs    = out_hs;
  assign bus.op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_shift_pass_sequencer.sv
// Directed bench for shift_pass_sequencer with a behavioural 16-bit shifter on sh_*.
module tb_shift_pass_sequencer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   hs_count;

  shift_pass_sequencer_if bus ();

  shift_pass_sequencer #(.MAX_STEP(15)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.sh_y = bus.sh_choice ? (bus.sh_a >> bus.sh_amt) : (bus.sh_a << bus.sh_amt);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef SHIFT_PASS_OP_COUNT_EN
    return 16'(n);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic request(input logic [15:0] d, input logic [4:0] a, input logic dir);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_dir   = dir;
  endtask

  initial begin
    checks = 0; failures = 0; hs_count = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 16'h0; bus.in_amt = 5'd0; bus.in_dir = 1'b0;
    bus.out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 16'h0000);
    chk("rst_sh_a", bus.sh_a, 16'h0000);
    chk("rst_sh_amt", bus.sh_amt, 0);
    chk("rst_sh_choice", bus.sh_choice, 0);
    chk("rst_op_count", bus.op_count, 16'h0000);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", bus.in_ready, 1);

    // 0x8001 << 1
    request(16'h8001, 5'd1, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t1_run_sh_amt", bus.sh_amt, 1);
    chk("t1_run_sh_a", bus.sh_a, 16'h8001);
    chk("t1_run_in_ready", bus.in_ready, 0);
    chk("t1_run_out_valid", bus.out_valid, 0);
    tick();
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_out_data", bus.out_data, 16'h0002);
    chk("t1_done_sh_amt", bus.sh_amt, 0);
    tick(); hs_count++;
    chk("t1_in_ready_back", bus.in_ready, 1);
    chk("t1_out_valid_low", bus.out_valid, 0);
    chk("t1_op_count", bus.op_count, exp_cnt(hs_count));

    // amt=0 passes straight through
    request(16'h1234, 5'd0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("t2_out_valid", bus.out_valid, 1);
    chk("t2_out_data", bus.out_data, 16'h1234);
    chk("t2_sh_amt", bus.sh_amt, 0);
    tick(); hs_count++;
    chk("t2_in_ready", bus.in_ready, 1);

    // 0x8000 >> 31 in passes 15,15,1 then backpressure
    bus.out_ready = 1'b0;
    request(16'h8000, 5'd31, 1'b1);
    tick();
    request(16'hF000, 5'd12, 1'b1);
    chk("t3_p1_sh_amt", bus.sh_amt, 15);
    chk("t3_p1_sh_choice", bus.sh_choice, 1);
    tick();
    chk("t3_p2_sh_amt", bus.sh_amt, 15);
    chk("t3_p2_sh_a", bus.sh_a, 16'h0001);
    tick();
    chk("t3_p3_sh_amt", bus.sh_amt, 1);
    chk("t3_p3_sh_a", bus.sh_a, 16'h0000);
    chk("t3_p3_out_valid", bus.out_valid, 0);
    tick();
    chk("t3_out_valid", bus.out_valid, 1);
    chk("t3_out_data", bus.out_data, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_data", bus.out_data, 16'h0000);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_op_count", bus.op_count, exp_cnt(hs_count));
    end
    bus.out_ready = 1'b1;
    tick(); hs_count++;
    chk("bp_hs_in_ready", bus.in_ready, 1);
    chk("bp_hs_op_count", bus.op_count, exp_cnt(hs_count));
    tick();
    bus.in_valid = 1'b0;
    chk("t4b_sh_amt", bus.sh_amt, 12);
    tick();
    chk("t4b_out_valid", bus.out_valid, 1);
    chk("t4b_out_data", bus.out_data, 16'h000F);
    tick(); hs_count++;

    // 0x00F0 << 16 -> passes 15, 1
    request(16'h00F0, 5'd16, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("t4_p1_sh_amt", bus.sh_amt, 15);
    tick();
    chk("t4_p2_sh_amt", bus.sh_amt, 1);
    tick();
    chk("t4_out_valid", bus.out_valid, 1);
    chk("t4_out_data", bus.out_data, 16'h0000);
    tick(); hs_count++;
    chk("t4_op_count", bus.op_count, exp_cnt(hs_count));

    // reset during the second RUN pass of amt=20
    request(16'hFFFF, 5'd20, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("t5_p1_sh_amt", bus.sh_amt, 15);
    tick();
    chk("t5_p2_sh_amt", bus.sh_amt, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hs_count = 0;
    chk("t5_rst_in_ready", bus.in_ready, 1);
    chk("t5_rst_out_valid", bus.out_valid, 0);
    chk("t5_rst_op_count", bus.op_count, 16'h0000);
    chk("t5_rst_sh_amt", bus.sh_amt, 0);
    request(16'h0001, 5'd3, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("t6_sh_amt", bus.sh_amt, 3);
    tick();
    chk("t6_out_valid", bus.out_valid, 1);
    chk("t6_out_data", bus.out_data, 16'h0008);
    tick(); hs_count++;
    chk("t6_op_count", bus.op_count, exp_cnt(hs_count));
    chk("t6_in_ready", bus.in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
